// File: rtl/snake_head_stepper.sv
// Snake head stepper: holds the head coordinates and advances them by one grid
// cell per accepted game tick. The addition goes through an external 10-bit
// adder. This block drives the adder operands for one cycle, registers the
// sum, then applies screen-edge wrap-around before updating the head.
// Requests for a 180-degree reversal keep the current direction.
module snake_head_stepper #(
   parameter int unsigned STEP   = 10,
   parameter int unsigned X_MAX  = 630,
   parameter int unsigned Y_MAX  = 470,
   parameter int unsigned X_INIT = 320,
   parameter int unsigned Y_INIT = 240
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       tick_i,
   input  logic [1:0] dir_in_i,
   output logic [9:0] add_a_o,
   output logic [9:0] add_b_o,
   input  logic [9:0] add_s_i,
   output logic [9:0] head_x_o,
   output logic [9:0] head_y_o,
   output logic [1:0] dir_cur_o,
   output logic       busy_o,
   output logic       step_done_o,
   output logic       wrapped_o
);

   // 10-bit versions of the parameters. The negative step is the
   // two's-complement of STEP, so the adder performs a subtraction.
   localparam logic [9:0] STEP_P   = 10'(STEP);
   localparam logic [9:0] STEP_NEG = (~STEP_P) + 10'd1;
   localparam logic [9:0] X_MAX_P  = 10'(X_MAX);
   localparam logic [9:0] Y_MAX_P  = 10'(Y_MAX);
   localparam logic [9:0] X_INIT_P = 10'(X_INIT);
   localparam logic [9:0] Y_INIT_P = 10'(Y_INIT);

   // Direction encoding: 00 up, 01 down, 10 left, 11 right.
   localparam logic [1:0] DIR_RIGHT = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ADD   = 2'b01,
      ST_CHECK = 2'b10
   } state_t;

   // Two directions on the same axis (same bit 1) that differ in sign
   // (bit 0) are exact opposites.
   function automatic logic is_reversal(input logic [1:0] req, input logic [1:0] cur);
      return (req[1] == cur[1]) && (req[0] != cur[0]);
   endfunction

   // Left and right move along x; up and down move along y.
   function automatic logic is_horizontal(input logic [1:0] dir);
      return dir[1];
   endfunction

   // Up and left decrease the coordinate.
   function automatic logic is_negative(input logic [1:0] dir);
      return ~dir[0];
   endfunction

   state_t     state_q, state_d;
   logic [9:0] head_x_q, head_x_d;
   logic [9:0] head_y_q, head_y_d;
   logic [1:0] dir_q, dir_d;
   logic [9:0] sum_q, sum_d;
   logic       under_q, under_d;
   logic [9:0] add_a_q, add_a_d;
   logic [9:0] add_b_q, add_b_d;
   logic       busy_q, busy_d;
   logic       step_done_q, step_done_d;
   logic       wrapped_q, wrapped_d;

   logic [1:0] dir_sel_s;
   logic [9:0] axis_max_s;
   logic [9:0] new_coord_s;
   logic       wrap_s;

   // Direction that a tick accepted now would latch; reversals keep the current one.
   always_comb begin
      dir_sel_s = dir_q;
      if (is_reversal(dir_in_i, dir_q)) begin
         dir_sel_s = dir_q;
      end else begin
         dir_sel_s = dir_in_i;
      end
   end

   // Wrap-around resolution of the registered sum for the axis being moved.
   always_comb begin
      axis_max_s  = Y_MAX_P;
      new_coord_s = sum_q;
      wrap_s      = 1'b0;
      if (is_horizontal(dir_q)) begin
         axis_max_s = X_MAX_P;
      end else begin
         axis_max_s = Y_MAX_P;
      end
      if (is_negative(dir_q)) begin
         if (under_q) begin
            new_coord_s = axis_max_s;
            wrap_s      = 1'b1;
         end else begin
            new_coord_s = sum_q;
            wrap_s      = 1'b0;
         end
      end else begin
         if (sum_q > axis_max_s) begin
            new_coord_s = 10'd0;
            wrap_s      = 1'b1;
         end else begin
            new_coord_s = sum_q;
            wrap_s      = 1'b0;
         end
      end
   end

   // Step FSM: next state plus next values of every registered output.
   always_comb begin
      state_d     = state_q;
      head_x_d    = head_x_q;
      head_y_d    = head_y_q;
      dir_d       = dir_q;
      sum_d       = sum_q;
      under_d     = under_q;
      add_a_d     = 10'd0;
      add_b_d     = 10'd0;
      busy_d      = busy_q;
      step_done_d = 1'b0;
      wrapped_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (tick_i) begin
               // Operands are registered here so they are stable at the
               // adder for the whole ADD cycle.
               dir_d = dir_sel_s;
               if (is_horizontal(dir_sel_s)) begin
                  add_a_d = head_x_q;
               end else begin
                  add_a_d = head_y_q;
               end
               if (is_negative(dir_sel_s)) begin
                  add_b_d = STEP_NEG;
               end else begin
                  add_b_d = STEP_P;
               end
               busy_d  = 1'b1;
               state_d = ST_ADD;
            end else begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         ST_ADD: begin
            // Underflow is detected on the operand, not on the wrapped sum.
            sum_d = add_s_i;
            if (is_negative(dir_q)) begin
               under_d = (add_a_q < STEP_P);
            end else begin
               under_d = 1'b0;
            end
            busy_d  = 1'b1;
            state_d = ST_CHECK;
         end
         ST_CHECK: begin
            if (is_horizontal(dir_q)) begin
               head_x_d = new_coord_s;
            end else begin
               head_y_d = new_coord_s;
            end
            step_done_d = 1'b1;
            wrapped_d   = wrap_s;
            busy_d      = 1'b0;
            state_d     = ST_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; synchronous reset discards any in-flight step.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         head_x_q    <= X_INIT_P;
         head_y_q    <= Y_INIT_P;
         dir_q       <= DIR_RIGHT;
         sum_q       <= 10'd0;
         under_q     <= 1'b0;
         add_a_q     <= 10'd0;
         add_b_q     <= 10'd0;
         busy_q      <= 1'b0;
         step_done_q <= 1'b0;
         wrapped_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         head_x_q    <= head_x_d;
         head_y_q    <= head_y_d;
         dir_q       <= dir_d;
         sum_q       <= sum_d;
         under_q     <= under_d;
         add_a_q     <= add_a_d;
         add_b_q     <= add_b_d;
         busy_q      <= busy_d;
         step_done_q <= step_done_d;
         wrapped_q   <= wrapped_d;
      end
   end

   assign add_a_o     = add_a_q;
   assign add_b_o     = add_b_q;
   assign head_x_o    = head_x_q;
   assign head_y_o    = head_y_q;
   assign dir_cur_o   = dir_q;
   assign busy_o      = busy_q;
   assign step_done_o = step_done_q;
   assign wrapped_o   = wrapped_q;

endmodule

// File: tb/tb_snake_head_stepper.sv
// Testbench for snake_head_stepper: directed scenarios plus a randomized run
// checked against a coordinate-level model of the snake head.
module tb_snake_head_stepper;

   logic       clk;
   logic       rst;
   logic       tick;
   logic [1:0] dir_in;
   logic [9:0] add_a;
   logic [9:0] add_b;
   logic [9:0] add_s;
   logic [9:0] head_x;
   logic [9:0] head_y;
   logic [1:0] dir_cur;
   logic       busy;
   logic       step_done;
   logic       wrapped;

   int n_checks = 0;
   int n_fail   = 0;

   snake_head_stepper dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .tick_i      (tick),
      .dir_in_i    (dir_in),
      .add_a_o     (add_a),
      .add_b_o     (add_b),
      .add_s_i     (add_s),
      .head_x_o    (head_x),
      .head_y_o    (head_y),
      .dir_cur_o   (dir_cur),
      .busy_o      (busy),
      .step_done_o (step_done),
      .wrapped_o   (wrapped)
   );

   // External 10-bit adder, carry discarded.
   assign add_s = add_a + add_b;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and settle just after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Issue one tick and report operands in ADD, pulses after E2 and one cycle later.
   task automatic issue_tick(input logic [1:0] d, output logic [9:0] oa, output logic [9:0] ob,
                             output logic done, output logic wr, output logic done_after);
      tick = 1'b1; dir_in = d;
      cyc();
      tick = 1'b0;
      oa = add_a; ob = add_b;
      cyc();
      cyc();
      done = step_done; wr = wrapped;
      cyc();
      done_after = step_done;
   endtask

   task automatic apply_reset();
      rst = 1'b1; tick = 1'b0; dir_in = 2'b00;
      cyc();
      cyc();
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_reset();
      apply_reset();
      n_checks++;
      if (head_x !== 10'd320 || head_y !== 10'd240 || dir_cur !== 2'b11) begin
         n_fail++;
         $display("FAIL reset_head: got x=%0d y=%0d dir=%b, expected x=320 y=240 dir=11", head_x, head_y, dir_cur);
      end
      n_checks++;
      if (busy !== 1'b0 || step_done !== 1'b0 || wrapped !== 1'b0 || add_a !== 10'd0 || add_b !== 10'd0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got busy=%b done=%b wr=%b a=%0d b=%0d, expected all 0", busy, step_done, wrapped, add_a, add_b);
      end
   endtask

   task automatic test_right_step();
      logic [9:0] oa, ob;
      logic done, wr, done_after;
      apply_reset();
      issue_tick(2'b11, oa, ob, done, wr, done_after);
      n_checks++;
      if (oa !== 10'd320 || ob !== 10'd10) begin
         n_fail++;
         $display("FAIL right_operands: got a=%0d b=%0d, expected a=320 b=10", oa, ob);
      end
      n_checks++;
      if (done !== 1'b1 || wr !== 1'b0 || done_after !== 1'b0) begin
         n_fail++;
         $display("FAIL right_pulses: got done=%b wr=%b next_done=%b, expected 1 0 0", done, wr, done_after);
      end
      n_checks++;
      if (head_x !== 10'd330 || head_y !== 10'd240 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL right_head: got x=%0d y=%0d busy=%b, expected x=330 y=240 busy=0", head_x, head_y, busy);
      end
   endtask

   task automatic test_reversal_busy();
      logic [9:0] oa, ob;
      logic done, wr, done_after;
      int dones;
      // Continues from x=330, direction right.
      issue_tick(2'b10, oa, ob, done, wr, done_after);
      n_checks++;
      if (dir_cur !== 2'b11 || head_x !== 10'd340 || ob !== 10'd10 || done !== 1'b1) begin
         n_fail++;
         $display("FAIL reversal: got dir=%b x=%0d b=%0d done=%b, expected dir=11 x=340 b=10 done=1", dir_cur, head_x, ob, done);
      end
      // Second tick one cycle after the accepted one must be ignored.
      tick = 1'b1; dir_in = 2'b11;
      cyc();
      dir_in = 2'b00;
      cyc();
      tick = 1'b0;
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         if (step_done === 1'b1) dones++;
         cyc();
      end
      n_checks++;
      if (dones != 1 || head_x !== 10'd350 || head_y !== 10'd240 || dir_cur !== 2'b11) begin
         n_fail++;
         $display("FAIL busy_ignore: got dones=%0d x=%0d y=%0d dir=%b, expected 1 350 240 11", dones, head_x, head_y, dir_cur);
      end
   endtask

   task automatic test_reset_mid_step();
      logic [9:0] oa, ob;
      logic done, wr, done_after;
      int dones;
      apply_reset();
      tick = 1'b1; dir_in = 2'b01;
      cyc();
      tick = 1'b0; rst = 1'b1;
      cyc();
      rst = 1'b0;
      n_checks++;
      if (head_x !== 10'd320 || head_y !== 10'd240 || busy !== 1'b0 || step_done !== 1'b0 || dir_cur !== 2'b11) begin
         n_fail++;
         $display("FAIL midreset_state: got x=%0d y=%0d busy=%b done=%b dir=%b, expected 320 240 0 0 11",
                  head_x, head_y, busy, step_done, dir_cur);
      end
      dones = 0;
      for (int i = 0; i < 4; i++) begin
         if (step_done === 1'b1) dones++;
         cyc();
      end
      n_checks++;
      if (dones != 0 || head_y !== 10'd240) begin
         n_fail++;
         $display("FAIL midreset_nostep: got dones=%0d y=%0d, expected 0 240", dones, head_y);
      end
      issue_tick(2'b11, oa, ob, done, wr, done_after);
      n_checks++;
      if (oa !== 10'd320 || ob !== 10'd10 || done !== 1'b1 || head_x !== 10'd330) begin
         n_fail++;
         $display("FAIL midreset_next: got a=%0d b=%0d done=%b x=%0d, expected 320 10 1 330", oa, ob, done, head_x);
      end
   endtask

   task automatic test_left_wrap();
      logic [9:0] oa, ob;
      logic done, wr, done_after;
      int bad;
      apply_reset();
      issue_tick(2'b00, oa, ob, done, wr, done_after);   // up first, so left is not a reversal
      bad = 0;
      for (int k = 1; k <= 32; k++) begin
         issue_tick(2'b10, oa, ob, done, wr, done_after);
         if (head_x !== 10'(320 - 10 * k) || wr !== 1'b0 || done !== 1'b1) bad++;
      end
      n_checks++;
      if (bad != 0 || head_x !== 10'd0 || head_y !== 10'd230) begin
         n_fail++;
         $display("FAIL left_walk: got bad_steps=%0d x=%0d y=%0d, expected 0 0 230", bad, head_x, head_y);
      end
      issue_tick(2'b10, oa, ob, done, wr, done_after);
      n_checks++;
      if (oa !== 10'd0 || ob !== 10'd1014) begin
         n_fail++;
         $display("FAIL left_wrap_operands: got a=%0d b=%0d, expected 0 1014", oa, ob);
      end
      n_checks++;
      if (head_x !== 10'd630 || wr !== 1'b1 || done !== 1'b1 || done_after !== 1'b0) begin
         n_fail++;
         $display("FAIL left_wrap: got x=%0d wr=%b done=%b next_done=%b, expected 630 1 1 0", head_x, wr, done, done_after);
      end
   endtask

   task automatic test_down_up_wrap();
      logic [9:0] oa, ob;
      logic done, wr, done_after;
      int bad;
      apply_reset();
      bad = 0;
      for (int k = 1; k <= 23; k++) begin
         issue_tick(2'b01, oa, ob, done, wr, done_after);
         if (head_y !== 10'(240 + 10 * k) || wr !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0 || head_y !== 10'd470) begin
         n_fail++;
         $display("FAIL down_walk: got bad_steps=%0d y=%0d, expected 0 470", bad, head_y);
      end
      issue_tick(2'b01, oa, ob, done, wr, done_after);
      n_checks++;
      if (head_y !== 10'd0 || wr !== 1'b1 || done !== 1'b1 || head_x !== 10'd320) begin
         n_fail++;
         $display("FAIL down_wrap: got y=%0d wr=%b done=%b x=%0d, expected 0 1 1 320", head_y, wr, done, head_x);
      end
      issue_tick(2'b11, oa, ob, done, wr, done_after);   // sideways so up is not a reversal
      issue_tick(2'b00, oa, ob, done, wr, done_after);
      n_checks++;
      if (oa !== 10'd0 || ob !== 10'd1014 || head_y !== 10'd470 || wr !== 1'b1 || head_x !== 10'd330) begin
         n_fail++;
         $display("FAIL up_wrap: got a=%0d b=%0d y=%0d wr=%b x=%0d, expected 0 1014 470 1 330", oa, ob, head_y, wr, head_x);
      end
   endtask

   // Randomized ticks and directions against a coordinate-level model.
   task automatic test_random();
      int mx, my, md, pend, exp_x, exp_y;
      int exp_a, exp_b, errs;
      logic exp_done, exp_wr, t;
      logic [1:0] d;
      apply_reset();
      mx = 320; my = 240; md = 3; pend = 0; errs = 0;
      for (int c = 0; c < 1500; c++) begin
         t = ($urandom_range(0, 2) == 0);
         d = 2'($urandom_range(0, 3));
         tick = t; dir_in = d;
         cyc();
         exp_done = 1'b0; exp_wr = 1'b0; exp_a = 0; exp_b = 0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               exp_done = 1'b1;
               exp_x = mx; exp_y = my;
               case (md)
                  0: begin exp_y = my - 10; if (exp_y < 0)   begin exp_y = 470; exp_wr = 1'b1; end end
                  1: begin exp_y = my + 10; if (exp_y > 470) begin exp_y = 0;   exp_wr = 1'b1; end end
                  2: begin exp_x = mx - 10; if (exp_x < 0)   begin exp_x = 630; exp_wr = 1'b1; end end
                  default: begin exp_x = mx + 10; if (exp_x > 630) begin exp_x = 0; exp_wr = 1'b1; end end
               endcase
               mx = exp_x; my = exp_y;
            end
         end else if (t) begin
            // Opposite directions differ only in the sign within an axis pair.
            if (!((int'(d) / 2 == md / 2) && (int'(d) != md))) md = int'(d);
            pend = 2;
            exp_a = (md >= 2) ? mx : my;
            exp_b = (md == 0 || md == 2) ? 1024 - 10 : 10;
         end
         n_checks++;
         if (head_x !== 10'(mx) || head_y !== 10'(my) || dir_cur !== 2'(md) || busy !== (pend > 0)
             || step_done !== exp_done || wrapped !== exp_wr) begin
            n_fail++;
            errs++;
            if (errs <= 10)
               $display("FAIL random_state cyc=%0d: got x=%0d y=%0d dir=%b busy=%b done=%b wr=%b, expected x=%0d y=%0d dir=%0d busy=%0d done=%b wr=%b",
                        c, head_x, head_y, dir_cur, busy, step_done, wrapped, mx, my, md, (pend > 0), exp_done, exp_wr);
         end
         if (pend != 1) begin
            n_checks++;
            if (add_a !== 10'(exp_a) || add_b !== 10'(exp_b)) begin
               n_fail++;
               errs++;
               if (errs <= 10)
                  $display("FAIL random_operands cyc=%0d: got a=%0d b=%0d, expected a=%0d b=%0d", c, add_a, add_b, exp_a, exp_b);
            end
         end
      end
      tick = 1'b0;
   endtask

   initial begin
      rst = 1'b1; tick = 1'b0; dir_in = 2'b00;
      test_reset();
      test_right_step();
      test_reversal_busy();
      test_reset_mid_step();
      test_left_wrap();
      test_down_up_wrap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
